gamepad_event_arbiter: RTL and testbench
========================================

Name: gamepad_event_arbiter

Overview:
- Sits between the gamepad Pmod decoder outputs (one or two players) and game logic.
- On each new gamepad frame, snapshots both players' 12-bit button vectors and computes press and release edges, plus optional D-pad auto-repeat.
- Serialises the resulting events into a small FIFO, alternating which player is scanned first on each frame for fairness.
- Consumer drains the FIFO with a valid/ready handshake.

Parameters:
- FIFO_DEPTH, 8: event FIFO entries; power of 2, minimum 2.
- REPEAT_DELAY, 20: frames a D-pad button must be held before the first repeat event.
- REPEAT_PERIOD, 5: frames between subsequent repeat events; 1 <= REPEAT_PERIOD <= REPEAT_DELAY <= 255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- frame_valid  in  1  one-cycle pulse: new decoded data available
- btn_p0  in  12  player 0 buttons {b,y,select,start,up,down,left,right,a,x,l,r}, bit11=b ... bit0=r, 1=pressed
- btn_p1  in  12  player 1 buttons, same packing
- present  in  2  per-player connected flag
- evt_valid  out  1  FIFO head valid
- evt_ready  in  1  consumer accepts head
- evt_player  out  1  player of head event
- evt_button  out  4  bit index 0..11 of head event
- evt_kind  out  2  0=release, 1=press, 2=repeat
- busy  out  1  scan in progress
- overflow  out  1  sticky: an event was dropped
- missed_frame  out  1  sticky: frame_valid arrived while busy
- clr_status  in  1  clears overflow and missed_frame

Behaviour:
- Reset: all outputs 0; FIFO empty; prev snapshots 0; repeat counters 0; start-player pointer 0; FSM IDLE.
- Inputs masked: effective btn_pX = present[X] ? btn_pX : 0. A disconnect therefore yields release events for held buttons.
- FSM states: IDLE, SCAN.
  - IDLE, frame_valid=1:
    - cur_pX <= masked inputs.
    - Update repeat counters.
    - slot <= 0.
    - First player <= start pointer.
    - Go to SCAN next cycle.
  - SCAN: one slot per cycle, 24 slots total.
    - Slots 0..11 = first player, bit 11 down to 0.
    - Slots 12..23 = other player, bit 11 down to 0.
  - After slot 23:
    - prev_pX <= cur_pX.
    - Toggle start pointer.
    - Return to IDLE.
  - Busy = (state == SCAN).
  - Frame to last push takes 24 cycles; the 25th cycle is IDLE.
- Per-slot event priority:
  - cur & ~prev -> press.
  - ~cur & prev -> release.
  - cur & prev & repeat_fire[player] & bit in 7..4 (D-pad) -> repeat.
  - Otherwise no push.
  - At most one event per slot.
- Repeat counter, per player, 8-bit, updated at snapshot:
  - If no D-pad bit is held in the new snapshot, or the held D-pad set differs from prev: cnt <= 0, fire = 0.
  - Else cnt+1. When it reaches REPEAT_DELAY: fire = 1 for this frame and cnt <= REPEAT_DELAY - REPEAT_PERIOD.
- frame_valid while in SCAN: ignored; missed_frame <= 1.
- FIFO:
  - Push when a slot produces an event and the FIFO is not full.
  - If full: drop the event and set overflow <= 1.
  - Pop when evt_valid & evt_ready.
  - Push and pop in the same cycle while full: pop frees space, push accepted, count unchanged.
  - Outputs come from the registered head; evt_* are stable while evt_valid & ~evt_ready.
  - Pointers wrap modulo FIFO_DEPTH.
- clr_status and a new sticky set in the same cycle: the set wins.
- rst_n low mid-scan: immediate return to reset state; FIFO contents lost.

Optional Feature:
- Macro GAMEPAD_EVT_AUTOREPEAT_EN.
  - Defined: repeat counters and repeat events exist as described.
  - Undefined: counters are absent, evt_kind never equals 2, REPEAT_* parameters are ignored.

Decomposition:
- Shared package gamepad_evt_pkg holds:
  - EVT_RELEASE/EVT_PRESS/EVT_REPEAT constants.
  - Button index constants (BTN_B=11 ... BTN_R=0, DPAD_LO=4, DPAD_HI=7).
  - Event struct {player, button[3:0], kind[1:0]}.
- One sub-module, gamepad_evt_fifo: synchronous FIFO with full/empty outputs and a show-ahead head.

Test Plan:
- P0 present, frame with btn_p0=0x800 (b) after all-zero -> exactly one event {p0, 11, press}. busy is high for 24 cycles.
- Next frame btn_p0=0x000 -> {p0, 11, release}. Frame with present=2'b01 and btn_p1=0xFFF -> no p1 events.
- Both players press a (bit 3) on the same frame, start pointer 0 -> p0 event first. On the next simultaneous press-after-release frame, p1 event first.
- With AUTOREPEAT_EN, defaults, hold up (bit 7) on p0 -> press on frame 1, repeats on frames 21, 26, 31. Adding left on frame 28 resets cnt; left gets a press event.
- Hold evt_ready=0, frame with 12 p0 presses, FIFO_DEPTH=8 -> 8 events retained in bit order 11..4, overflow=1. clr_status -> overflow=0.
- frame_valid pulsed 5 cycles after a previous frame -> missed_frame=1, no extra events. Reset asserted mid-scan -> evt_valid=0 and busy=0 next cycle.

Source files
------------

// File: rtl/gamepad_evt_pkg.sv
// Shared types and constants for the gamepad event arbiter: event kinds,
// button bit positions, the event record and the scan FSM encoding.
package gamepad_evt_pkg;

    localparam logic [1:0] EVT_RELEASE = 2'd0;
    localparam logic [1:0] EVT_PRESS   = 2'd1;
    localparam logic [1:0] EVT_REPEAT  = 2'd2;

    localparam int BTN_B      = 11;
    localparam int BTN_Y      = 10;
    localparam int BTN_SELECT = 9;
    localparam int BTN_START  = 8;
    localparam int BTN_UP     = 7;
    localparam int BTN_DOWN   = 6;
    localparam int BTN_LEFT   = 5;
    localparam int BTN_RIGHT  = 4;
    localparam int BTN_A      = 3;
    localparam int BTN_X      = 2;
    localparam int BTN_L      = 1;
    localparam int BTN_R      = 0;
    localparam int DPAD_LO    = 4;
    localparam int DPAD_HI    = 7;

    localparam int N_BTN  = 12;
    localparam int N_SLOT = 2 * N_BTN;

    typedef struct packed {
        logic       player;
        logic [3:0] button;
        logic [1:0] kind;
    } evt_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/gamepad_event_arbiter_if.sv
// Event stream from the arbiter to game logic: show-ahead head with valid/ready.
interface gamepad_event_arbiter_if;
    logic       evt_valid;
    logic       evt_ready;
    logic       evt_player;
    logic [3:0] evt_button;
    logic [1:0] evt_kind;

    modport master (output evt_valid, evt_player, evt_button, evt_kind, input evt_ready);
    modport slave  (input evt_valid, evt_player, evt_button, evt_kind, output evt_ready);
endinterface

// File: rtl/gamepad_evt_fifo.sv
// Synchronous event FIFO with show-ahead head; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module gamepad_evt_fifo
    import gamepad_evt_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  evt_t push_data,
    input  logic pop,
    output logic full,
    output logic empty,
    output evt_t head
);
    localparam int AW = $clog2(DEPTH);

    evt_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count alone says which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/gamepad_event_arbiter.sv
// Snapshots both players' buttons per frame and serialises press/release
// (and, with GAMEPAD_EVT_AUTOREPEAT_EN, D-pad repeat) events into a FIFO.
module gamepad_event_arbiter
    import gamepad_evt_pkg::*;
#(
    parameter int FIFO_DEPTH    = 8,
    parameter int REPEAT_DELAY  = 20,
    parameter int REPEAT_PERIOD = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          frame_valid,
    input  logic [11:0]                   btn_p0,
    input  logic [11:0]                   btn_p1,
    input  logic [1:0]                    present,
    gamepad_event_arbiter_if.master       evt,
    output logic                          busy,
    output logic                          overflow,
    output logic                          missed_frame,
    input  logic                          clr_status
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end
    if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY || REPEAT_DELAY > 255) begin : g_bad_repeat
        $error("need 1 <= REPEAT_PERIOD <= REPEAT_DELAY <= 255");
    end

    state_t          state;
    state_t          state_nxt;
    logic [4:0]      slot;
    logic            start_ptr;
    logic            first_q;
    logic [1:0][11:0] snap;
    logic [1:0][11:0] cur_q;
    logic [1:0][11:0] prev_q;
    logic [1:0]      fire;
    logic            frame_accept;
    logic            last_slot;
    logic            second_half;
    logic            scan_player;
    logic [3:0]      scan_bit;
    logic            cur_bit;
    logic            prev_bit;
    logic            in_dpad;
    logic            slot_push;
    evt_t            slot_evt;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_pop;
    evt_t            fifo_head;

    assign snap[0]      = present[0] ? btn_p0 : '0;
    assign snap[1]      = present[1] ? btn_p1 : '0;
    assign frame_accept = frame_valid & (state == ST_IDLE);
    assign last_slot    = (state == ST_SCAN) && (slot == 5'(N_SLOT - 1));

    // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (frame_valid) state_nxt = ST_SCAN;
            ST_SCAN: if (last_slot)   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        unique case (state)
            ST_SCAN: busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot      <= '0;
            start_ptr <= 1'b0;
            first_q   <= 1'b0;
            cur_q     <= '0;
            prev_q    <= '0;
        end else if (frame_accept) begin
            cur_q   <= snap;
            slot    <= '0;
            first_q <= start_ptr;
        end else if (busy) begin
            slot <= slot + 1'b1;
            if (last_slot) begin
                prev_q    <= cur_q;
                start_ptr <= ~start_ptr;
            end
        end
    end

`ifdef GAMEPAD_EVT_AUTOREPEAT_EN
    logic [1:0][7:0] rpt_cnt;

    // A changed or empty D-pad set restarts the hold; reaching the delay
    // fires once and rewinds so the next fire lands REPEAT_PERIOD frames later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rpt_cnt <= '0;
            fire    <= '0;
        end else if (frame_accept) begin
            for (int p = 0; p < 2; p++) begin
                if (snap[p][DPAD_HI:DPAD_LO] == '0 ||
                    snap[p][DPAD_HI:DPAD_LO] != prev_q[p][DPAD_HI:DPAD_LO]) begin
                    rpt_cnt[p] <= '0;
                    fire[p]    <= 1'b0;
                end else if (rpt_cnt[p] + 8'd1 == 8'(REPEAT_DELAY)) begin
                    rpt_cnt[p] <= 8'(REPEAT_DELAY - REPEAT_PERIOD);
                    fire[p]    <= 1'b1;
                end else begin
                    rpt_cnt[p] <= rpt_cnt[p] + 8'd1;
                    fire[p]    <= 1'b0;
                end
            end
        end
    end
`else
    assign fire = '0;
`endif

    assign second_half = (slot >= 5'(N_BTN));
    assign scan_player = first_q ^ second_half;
    assign scan_bit    = second_half ? 4'(5'(N_SLOT - 1) - slot) : 4'(5'(N_BTN - 1) - slot);
    assign cur_bit     = cur_q[scan_player][scan_bit];
    assign prev_bit    = prev_q[scan_player][scan_bit];
    assign in_dpad     = (scan_bit >= 4'(DPAD_LO)) && (scan_bit <= 4'(DPAD_HI));

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        slot_push       = 1'b0;
        slot_evt.player = scan_player;
        slot_evt.button = scan_bit;
        slot_evt.kind   = EVT_PRESS;
        if (busy) begin
            if (cur_bit && !prev_bit) begin
                slot_push = 1'b1;
            end else if (!cur_bit && prev_bit) begin
                slot_push     = 1'b1;
                slot_evt.kind = EVT_RELEASE;
            end else if (cur_bit && prev_bit && fire[scan_player] && in_dpad) begin
                slot_push     = 1'b1;
                slot_evt.kind = EVT_REPEAT;
            end
        end
    end

    assign fifo_pop = evt.evt_valid & evt.evt_ready;

    gamepad_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (slot_push),
        .push_data (slot_evt),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign evt.evt_valid  = ~fifo_empty;
    assign evt.evt_player = fifo_head.player;
    assign evt.evt_button = fifo_head.button;
    assign evt.evt_kind   = fifo_head.kind;

    // A new sticky set outranks a clear arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow     <= 1'b0;
            missed_frame <= 1'b0;
        end else begin
            if (slot_push && fifo_full && !fifo_pop) overflow <= 1'b1;
            else if (clr_status)                     overflow <= 1'b0;
            if (frame_valid && busy)                 missed_frame <= 1'b1;
            else if (clr_status)                     missed_frame <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gamepad_event_arbiter.sv
// Self-checking bench: directed scenarios plus random frames, all compared
// every cycle against a queue-based event model; honours GAMEPAD_EVT_AUTOREPEAT_EN.
module tb_gamepad_event_arbiter;
    import gamepad_evt_pkg::*;

    localparam int DEPTH = 8;
    localparam int RD    = 20;
    localparam int RP    = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_valid;
    logic        clr_status;
    logic [11:0] btn_p0;
    logic [11:0] btn_p1;
    logic [1:0]  present;
    logic        busy;
    logic        overflow;
    logic        missed_frame;

    gamepad_event_arbiter_if evt_if ();

    gamepad_event_arbiter #(
        .FIFO_DEPTH(DEPTH), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_valid  (frame_valid),
        .btn_p0       (btn_p0),
        .btn_p1       (btn_p1),
        .present      (present),
        .evt          (evt_if),
        .busy         (busy),
        .overflow     (overflow),
        .missed_frame (missed_frame),
        .clr_status   (clr_status)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int rep_seen = 0;
    int busy_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---- behavioural model: pending slot list, event queue, sticky flags ----
    typedef struct packed { logic v; evt_t e; } slot_t;
    slot_t       m_pend[$];
    evt_t        m_fifo[$];
    logic [11:0] m_prev[2];
    bit          m_start;
    int          m_cnt[2];
    bit          m_ovf;
    bit          m_miss;

    task automatic model_reset();
        m_pend.delete();
        m_fifo.delete();
        m_prev[0] = '0;
        m_prev[1] = '0;
        m_start   = 1'b0;
        m_cnt[0]  = 0;
        m_cnt[1]  = 0;
        m_ovf     = 1'b0;
        m_miss    = 1'b0;
    endtask

    task automatic gen_frame(input logic [11:0] b0, input logic [11:0] b1, input logic [1:0] pres);
        logic [11:0] cur[2];
        bit          fire[2];
        cur[0] = pres[0] ? b0 : 12'h000;
        cur[1] = pres[1] ? b1 : 12'h000;
        for (int p = 0; p < 2; p++) begin
            fire[p] = 1'b0;
`ifdef GAMEPAD_EVT_AUTOREPEAT_EN
            if (cur[p][7:4] == 4'h0 || cur[p][7:4] != m_prev[p][7:4]) begin
                m_cnt[p] = 0;
            end else begin
                m_cnt[p] = m_cnt[p] + 1;
                if (m_cnt[p] == RD) begin
                    fire[p]  = 1'b1;
                    m_cnt[p] = RD - RP;
                end
            end
`endif
        end
        for (int k = 0; k < 2; k++) begin
            int pl;
            pl = (k == 0) ? int'(m_start) : int'(!m_start);
            for (int b = 11; b >= 0; b--) begin
                slot_t s;
                bit    c;
                bit    q;
                c = cur[pl][b];
                q = m_prev[pl][b];
                s.v        = 1'b1;
                s.e.player = pl[0];
                s.e.button = 4'(b);
                if (c && !q)                               s.e.kind = EVT_PRESS;
                else if (!c && q)                          s.e.kind = EVT_RELEASE;
                else if (c && q && fire[pl] && b >= 4 && b <= 7) s.e.kind = EVT_REPEAT;
                else begin
                    s.v = 1'b0;
                    s.e = '0;
                end
                m_pend.push_back(s);
            end
        end
        m_prev[0] = cur[0];
        m_prev[1] = cur[1];
        m_start   = !m_start;
    endtask

    task automatic model_step(input bit fv, input logic [11:0] b0, input logic [11:0] b1,
                              input logic [1:0] pres, input bit rdy, input bit clr);
        bit busy_now;
        bit ovf_set;
        bit miss_set;
        busy_now = (m_pend.size() > 0);
        ovf_set  = 1'b0;
        miss_set = 1'b0;
        if (m_fifo.size() > 0 && rdy) void'(m_fifo.pop_front());
        if (busy_now) begin
            slot_t s;
            s = m_pend.pop_front();
            if (s.v) begin
                if (m_fifo.size() < DEPTH) m_fifo.push_back(s.e);
                else                       ovf_set = 1'b1;
            end
        end
        if (fv) begin
            if (busy_now) miss_set = 1'b1;
            else          gen_frame(b0, b1, pres);
        end
        m_ovf  = ovf_set  | (m_ovf  & !clr);
        m_miss = miss_set | (m_miss & !clr);
    endtask

    task automatic compare();
        evt_t h;
        h = (m_fifo.size() > 0) ? m_fifo[0] : '0;
        check("busy",         busy,               m_pend.size() > 0);
        check("evt_valid",    evt_if.evt_valid,   m_fifo.size() > 0);
        check("evt_player",   evt_if.evt_player,  h.player);
        check("evt_button",   evt_if.evt_button,  h.button);
        check("evt_kind",     evt_if.evt_kind,    h.kind);
        check("overflow",     overflow,           m_ovf);
        check("missed_frame", missed_frame,       m_miss);
        if (evt_if.evt_valid && evt_if.evt_kind == EVT_REPEAT) rep_seen++;
        if (busy) busy_seen++;
    endtask

    task automatic step(input bit fv, input logic [11:0] b0, input logic [11:0] b1,
                        input logic [1:0] pres, input bit rdy, input bit clr, input bit rn);
        frame_valid      = fv;
        btn_p0           = b0;
        btn_p1           = b1;
        present          = pres;
        evt_if.evt_ready = rdy;
        clr_status       = clr;
        rst_n            = rn;
        if (!rn) model_reset();
        else     model_step(fv, b0, b1, pres, rdy, clr);
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    // One accepted frame followed by 25 quiet cycles, so the scan completes.
    task automatic frame(input logic [11:0] b0, input logic [11:0] b1,
                         input logic [1:0] pres, input bit rdy);
        step(1'b1, b0, b1, pres, rdy, 1'b0, 1'b1);
        for (int i = 0; i < 25; i++) step(1'b0, b0, b1, pres, rdy, 1'b0, 1'b1);
    endtask

    task automatic drain(input logic [11:0] b0, input logic [11:0] b1, input logic [1:0] pres);
        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, b0, b1, pres, 1'b1, 1'b0, 1'b1);
    endtask

    logic [11:0] rb0;
    logic [11:0] rb1;
    logic [1:0]  rpres;

    initial begin
        model_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 12'h000, 12'h000, 2'b00, 1'b0, 1'b0, 1'b0);
        check("reset_evt_valid", evt_if.evt_valid, 1'b0);
        check("reset_busy", busy, 1'b0);

        // single press on p0: exactly one event, 24 busy cycles
        busy_seen = 0;
        frame(12'h800, 12'h000, 2'b01, 1'b0);
        check("press_busy_cycles", busy_seen, 24);
        check("press_valid", evt_if.evt_valid, 1'b1);
        check("press_event", {evt_if.evt_player, evt_if.evt_button, evt_if.evt_kind}, {1'b0, 4'd11, EVT_PRESS});
        step(1'b0, 12'h800, 12'h000, 2'b01, 1'b1, 1'b0, 1'b1);
        check("press_only_one", evt_if.evt_valid, 1'b0);

        // release on p0, p1 absent so its all-pressed input is masked
        frame(12'h000, 12'hFFF, 2'b01, 1'b0);
        check("release_event", {evt_if.evt_player, evt_if.evt_button, evt_if.evt_kind}, {1'b0, 4'd11, EVT_RELEASE});
        step(1'b0, 12'h000, 12'hFFF, 2'b01, 1'b1, 1'b0, 1'b1);
        check("masked_p1_silent", evt_if.evt_valid, 1'b0);

        // fairness: start pointer alternates per frame
        frame(12'h008, 12'h008, 2'b11, 1'b0);
        check("fair_first_p0", {evt_if.evt_player, evt_if.evt_button}, {1'b0, 4'd3});
        step(1'b0, 12'h008, 12'h008, 2'b11, 1'b1, 1'b0, 1'b1);
        check("fair_second_p1", {evt_if.evt_player, evt_if.evt_button}, {1'b1, 4'd3});
        drain(12'h008, 12'h008, 2'b11);
        frame(12'h000, 12'h000, 2'b11, 1'b0);
        check("fair_first_p1", {evt_if.evt_player, evt_if.evt_kind}, {1'b1, EVT_RELEASE});
        drain(12'h000, 12'h000, 2'b11);

        // overflow: 12 presses into 8 entries keeps bits 11..4
        frame(12'hFFF, 12'h000, 2'b01, 1'b0);
        check("overflow_set", overflow, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            check("overflow_order", evt_if.evt_button, 32'(11 - i));
            step(1'b0, 12'hFFF, 12'h000, 2'b01, 1'b1, 1'b0, 1'b1);
        end
        check("overflow_kept_8", evt_if.evt_valid, 1'b0);
        step(1'b0, 12'hFFF, 12'h000, 2'b01, 1'b0, 1'b1, 1'b1);
        check("overflow_clear", overflow, 1'b0);

        // frame arriving mid-scan is dropped and flagged
        step(1'b1, 12'hFFF, 12'h000, 2'b01, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 12'hFFF, 12'h000, 2'b01, 1'b1, 1'b0, 1'b1);
        step(1'b1, 12'h000, 12'h000, 2'b01, 1'b1, 1'b0, 1'b1);
        check("missed_set", missed_frame, 1'b1);
        for (int i = 0; i < 25; i++) step(1'b0, 12'h000, 12'h000, 2'b01, 1'b1, 1'b0, 1'b1);
        check("missed_no_events", evt_if.evt_valid, 1'b0);
        step(1'b0, 12'hFFF, 12'h000, 2'b01, 1'b1, 1'b1, 1'b1);
        check("missed_clear", missed_frame, 1'b0);

`ifdef GAMEPAD_EVT_AUTOREPEAT_EN
        frame(12'h000, 12'h000, 2'b11, 1'b1);
        rep_seen = 0;
        for (int f = 1; f <= 31; f++) frame(12'h080, 12'h000, 2'b01, 1'b1);
        check("repeat_count_31", rep_seen, 3);
        frame(12'h0A0, 12'h000, 2'b01, 1'b0);
        check("left_press", {evt_if.evt_player, evt_if.evt_button, evt_if.evt_kind}, {1'b0, 4'd5, EVT_PRESS});
        drain(12'h0A0, 12'h000, 2'b01);
        rep_seen = 0;
        for (int f = 0; f < 5; f++) frame(12'h0A0, 12'h000, 2'b01, 1'b1);
        check("repeat_restarted", rep_seen, 0);
`endif

        // reset in the middle of a scan with events queued
        step(1'b1, 12'h00F, 12'h000, 2'b01, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 12'h00F, 12'h000, 2'b01, 1'b0, 1'b0, 1'b1);
        step(1'b0, 12'h00F, 12'h000, 2'b01, 1'b0, 1'b0, 1'b0);
        check("rst_mid_valid", evt_if.evt_valid, 1'b0);
        check("rst_mid_busy", busy, 1'b0);

        // random traffic against the model
        rb0   = '0;
        rb1   = '0;
        rpres = 2'b11;
        for (int i = 0; i < 4000; i++) begin
            bit fv;
            fv = ($urandom_range(0, 7) == 0);
            if (fv && $urandom_range(0, 3) != 0) begin
                rb0 = rb0 ^ 12'($urandom & $urandom & $urandom);
                rb1 = rb1 ^ 12'($urandom & $urandom & $urandom);
            end
            if ($urandom_range(0, 50) == 0) rpres = 2'($urandom);
            step(fv, rb0, rb1, rpres, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 60) == 0, $urandom_range(0, 1500) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
